branch_ctrl: RTL

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution controller: holds the ID stage while a branch waits for its
// operands, then drives the comparator and redirects the PC on a taken result.
module branch_ctrl #(
    parameter int DELAY_SLOT = 1,
    parameter int MAX_WAIT   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [2:0]  br_op,
    input  logic [31:0] br_target,
    input  logic        rs_pend,
    input  logic        rt_pend,
    input  logic        jumpEn,
    input  logic        stat_clr,
    output logic        cmp_valid,
    output logic [2:0]  cmp_branchOp,
    output logic        id_stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        if_flush,
    output logic [15:0] br_cnt,
    output logic [15:0] taken_cnt,
    output logic        wait_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] CMP   = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    localparam logic [3:0] WAIT_LAST  = 4'(MAX_WAIT - 1);
    localparam logic       DROP_SLOT  = 1'(DELAY_SLOT == 0);

    logic [1:0]  state_r;
    logic [1:0]  nextState_s;
    logic [3:0]  waitCnt_r;
    logic [2:0]  op_r;
    logic [31:0] target_r;
    logic [15:0] brCnt_r;
    logic [15:0] takenCnt_r;
    logic        waitErr_r;
    logic        pend_s;
    logic        accept_s;
    logic        timeout_s;
    logic        resolve_s;

    function automatic logic [15:0] satInc(input logic [15:0] value, input logic inc);
        logic [15:0] result;
        if (inc && (value != 16'hFFFF)) begin
            result = value + 16'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

    assign pend_s = rs_pend | rt_pend;

    // Next-state decode; operand readiness is checked before the wait timeout
    always_comb begin
        nextState_s = state_r;
        accept_s    = 1'b0;
        timeout_s   = 1'b0;
        resolve_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (br_valid) begin
                    accept_s    = 1'b1;
                    nextState_s = pend_s ? WAIT : CMP;
                end else begin
                    nextState_s = IDLE;
                end
            end
            WAIT: begin
                if (!pend_s) begin
                    nextState_s = CMP;
                end else if (waitCnt_r == WAIT_LAST) begin
                    timeout_s   = 1'b1;
                    nextState_s = IDLE;
                end else begin
                    nextState_s = WAIT;
                end
            end
            CMP: begin
                resolve_s = 1'b1;
                if (jumpEn && DROP_SLOT) begin
                    nextState_s = FLUSH;
                end else begin
                    nextState_s = IDLE;
                end
            end
            FLUSH: begin
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // FSM state, branch latch and operand-wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            waitCnt_r <= 4'd0;
            op_r      <= 3'd0;
            target_r  <= 32'd0;
        end else begin
            state_r <= nextState_s;
            if (accept_s) begin
                op_r      <= br_op;
                target_r  <= br_target;
                waitCnt_r <= 4'd0;
            end else if (state_r == WAIT) begin
                waitCnt_r <= waitCnt_r + 4'd1;
            end else begin
                waitCnt_r <= waitCnt_r;
            end
        end
    end

    // Statistics; a clear beats any increment or timeout in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brCnt_r    <= 16'd0;
            takenCnt_r <= 16'd0;
            waitErr_r  <= 1'b0;
        end else if (stat_clr) begin
            brCnt_r    <= 16'd0;
            takenCnt_r <= 16'd0;
            waitErr_r  <= 1'b0;
        end else begin
            brCnt_r    <= satInc(brCnt_r, resolve_s);
            takenCnt_r <= satInc(takenCnt_r, resolve_s & jumpEn);
            if (timeout_s) begin
                waitErr_r <= 1'b1;
            end else begin
                waitErr_r <= waitErr_r;
            end
        end
    end

    // Strobes are gated by reset so the acceptance stall cannot leak while held in reset
    assign id_stall     = reset & (accept_s | (state_r == WAIT));
    assign cmp_valid    = reset & (state_r == CMP);
    assign pc_redirect  = reset & (state_r == CMP) & jumpEn;
    assign if_flush     = reset & (state_r == FLUSH);
    assign cmp_branchOp = op_r;
    assign pc_target    = target_r;
    assign br_cnt       = brCnt_r;
    assign taken_cnt    = takenCnt_r;
    assign wait_err     = waitErr_r;

endmodule
